uart_tx_framer: RTL

- Parametrised UART transmit framer. Successor to the fixed 7/8-bit ninth/tenth-bit parity decoder.
- Accepts a parallel word through a load/ready handshake, double-buffers it, and serialises one complete frame: start bit, 5..DATA_W data bits LSB-first, optional parity, then 1 or 2 stop bits.
- Parity modes are even, odd, mark and space.
- Sits between the CPU/register interface and the tx pin.
- Contains its own per-bit baud divider.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_parity_gen.sv | 37 +++
 rtl/uart_tx_framer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART framer and the future receiver.
package uart_pkg;

  localparam int MIN_DATA_W   = 5;
  localparam int MIN_BAUD_DIV = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_state_e;

  // {stick, ohel} selects the parity flavour
  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_SPACE = 2'b10,
    PAR_MARK  = 2'b11
  } par_mode_e;

  function automatic par_mode_e par_mode(input logic stick, input logic ohel);
    return par_mode_e'({stick, ohel});
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parity bit over the low len_i bits of a data word; shared with the receiver.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              ohel_i,
  input  logic              stick_i,
  output logic              parity_o
);

  logic x;

  // XOR of the bits that actually go on the line
  always_comb begin
    x = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(len_i)) x = x ^ data_i[i];
    end
  end

  // Map the XOR onto the selected parity flavour
  always_comb begin
    parity_o = 1'b0;
    case (par_mode(stick_i, ohel_i))
      PAR_EVEN:  parity_o = x;
      PAR_ODD:   parity_o = ~x;
      PAR_SPACE: parity_o = 1'b0;
      PAR_MARK:  parity_o = 1'b1;
      default:   parity_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: double-buffered word in, start/data/parity/stop out.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | line high, waiting for a full holding register
// START  | start bit (0)
// DATA   | data bits LSB first, bit_q counts 0..len-1
// PARITY | parity bit from the captured word
// STOP1  | first stop bit (1)
// STOP2  | second stop bit (1), only when two_stop captured
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [LEN_W-1:0]  data_len,
  input  logic              pen,
  input  logic              ohel,
  input  logic              stick,
  input  logic              two_stop,
  input  logic              load,
  input  logic [DATA_W-1:0] ldata,
  output logic              txrdy,
  output logic              busy,
  output logic              tx,
  output logic              tx_done,
  output logic              load_err
);

  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_DATA_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_BAUD_DIV);

  // holding register and its configuration snapshot
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [LEN_W-1:0]  hold_len_q, hold_len_d;
  logic [DIV_W-1:0]  hold_div_q, hold_div_d;
  logic              hold_pen_q, hold_pen_d;
  logic              hold_two_q, hold_two_d;
  logic              hold_par_q, hold_par_d;

  // frame in progress
  uart_state_e       state_q, state_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [LEN_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]  cur_len_q, cur_len_d;
  logic [DIV_W-1:0]  cur_div_q, cur_div_d;
  logic              cur_pen_q, cur_pen_d;
  logic              cur_two_q, cur_two_d;
  logic              cur_par_q, cur_par_d;
  logic              tx_q, tx_d;
  logic              load_err_q, load_err_d;

  logic [LEN_W-1:0]  len_clamped;
  logic [DIV_W-1:0]  div_clamped;
  logic              par_bit;
  logic              accept;
  logic              last_tick;
  logic              last_stop;
  logic              frame_end;
  logic              xfer;

  // Clamp the live configuration before it is captured
  always_comb begin
    len_clamped = data_len;
    if (data_len < LEN_MIN) begin
      len_clamped = LEN_MIN;
    end else if (data_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
    div_clamped = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
  end

  // Parity is resolved at capture time so ohel/stick need not be held
  uart_parity_gen #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_parity (
    .data_i   (ldata),
    .len_i    (len_clamped),
    .ohel_i   (ohel),
    .stick_i  (stick),
    .parity_o (par_bit)
  );

  // Frame-boundary and handshake decode from registered state only
  always_comb begin
    accept    = load && !hold_full_q;
    last_tick = (baud_q == '0);
    last_stop = (state_q == STOP2) || ((state_q == STOP1) && !cur_two_q);
    frame_end = last_stop && last_tick;
    xfer      = hold_full_q && ((state_q == IDLE) || frame_end);
  end

  // Next-state logic for holding register, FSM and serial datapath
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    hold_div_d  = hold_div_q;
    hold_pen_d  = hold_pen_q;
    hold_two_d  = hold_two_q;
    hold_par_d  = hold_par_q;
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    cur_len_d   = cur_len_q;
    cur_div_d   = cur_div_q;
    cur_pen_d   = cur_pen_q;
    cur_two_d   = cur_two_q;
    cur_par_d   = cur_par_q;
    tx_d        = 1'b1;
    load_err_d  = load && hold_full_q;

    // accept and xfer are exclusive: accept needs empty, xfer needs full
    if (xfer) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = ldata;
      hold_len_d  = len_clamped;
      hold_div_d  = div_clamped;
      hold_pen_d  = pen;
      hold_two_d  = two_stop;
      hold_par_d  = par_bit;
    end

    if (xfer) begin
      state_d   = START;
      baud_d    = hold_div_q - DIV_W'(1);
      bit_d     = '0;
      shift_d   = hold_data_q;
      cur_len_d = hold_len_q;
      cur_div_d = hold_div_q;
      cur_pen_d = hold_pen_q;
      cur_two_d = hold_two_q;
      cur_par_d = hold_par_q;
    end else if (state_q != IDLE) begin
      if (!last_tick) begin
        baud_d = baud_q - DIV_W'(1);
      end else begin
        baud_d = cur_div_q - DIV_W'(1);
        case (state_q)
          START: begin
            state_d = DATA;
            bit_d   = '0;
          end
          DATA: begin
            shift_d = shift_q >> 1;
            if (bit_q == cur_len_q - LEN_W'(1)) begin
              state_d = cur_pen_q ? PARITY : STOP1;
            end else begin
              bit_d = bit_q + LEN_W'(1);
            end
          end
          PARITY:  state_d = STOP1;
          STOP1:   state_d = cur_two_q ? STOP2 : IDLE;
          STOP2:   state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = cur_par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // Holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_len_q  <= '0;
      hold_div_q  <= '0;
      hold_pen_q  <= 1'b0;
      hold_two_q  <= 1'b0;
      hold_par_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      hold_div_q  <= hold_div_d;
      hold_pen_q  <= hold_pen_d;
      hold_two_q  <= hold_two_d;
      hold_par_q  <= hold_par_d;
    end
  end

  // FSM state, counters, shifter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      cur_len_q  <= '0;
      cur_div_q  <= '0;
      cur_pen_q  <= 1'b0;
      cur_two_q  <= 1'b0;
      cur_par_q  <= 1'b0;
      tx_q       <= 1'b1;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      cur_len_q  <= cur_len_d;
      cur_div_q  <= cur_div_d;
      cur_pen_q  <= cur_pen_d;
      cur_two_q  <= cur_two_d;
      cur_par_q  <= cur_par_d;
      tx_q       <= tx_d;
      load_err_q <= load_err_d;
    end
  end

  assign txrdy    = ~hold_full_q;
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;
  assign tx_done  = frame_end;
  assign load_err = load_err_q;

endmodule
